// File: rtl/vending_pkg.sv
// Shared coin-code definitions for the vending machine and its input stage.
package vending_pkg;
  typedef logic [1:0] money_t;

  localparam money_t MONEY_NONE = 2'd0;
  localparam money_t MONEY_HALF = 2'd1;
  localparam money_t MONEY_ONE  = 2'd2;
endpackage

// File: rtl/key_filter.sv
// Synchronises and debounces one active-low key; o_press pulses once per stable press.
module key_filter #(
  parameter int CNT_MAX = 999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_key,
  output logic o_press
);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);
  localparam logic [CW-1:0] CNT_HIT = CW'(CNT_MAX - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_s;

  assign key_s = sync_q[1];

  // Saturating at CNT_TOP keeps a held key from firing again.
  always_comb begin
    cnt_d = cnt_q;
    if (key_s)                cnt_d = '0;
    else if (cnt_q < CNT_TOP) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], i_key};
      cnt_q  <= cnt_d;
    end
  end

  assign o_press = !key_s && (cnt_q == CNT_HIT);
endmodule

// File: rtl/coin_key_encoder.sv
// Turns two debounced coin keys into single-cycle coin codes; a coincident
// half coin is queued one cycle behind the one-unit coin.
module coin_key_encoder
  import vending_pkg::*;
#(
  parameter int CNT_MAX = 999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       i_key_half,
  input  logic       i_key_one,
  output logic [1:0] o_money,
  output logic       o_pending
);
  logic   press_half, press_one;
  money_t money_q, money_d;
  logic   pend_q, pend_d;

  key_filter #(.CNT_MAX(CNT_MAX)) u_half (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .i_key    (i_key_half),
    .o_press  (press_half)
  );

  key_filter #(.CNT_MAX(CNT_MAX)) u_one (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .i_key    (i_key_one),
    .o_press  (press_one)
  );

  // A fresh press always wins over the queued half coin, which stays queued.
  always_comb begin
    money_d = MONEY_NONE;
    pend_d  = pend_q;
    if (press_half && press_one) begin
      money_d = MONEY_ONE;
      pend_d  = 1'b1;
    end else if (press_one) begin
      money_d = MONEY_ONE;
    end else if (press_half) begin
      money_d = MONEY_HALF;
    end else if (pend_q) begin
      money_d = MONEY_HALF;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      money_q <= MONEY_NONE;
      pend_q  <= 1'b0;
    end else begin
      money_q <= money_d;
      pend_q  <= pend_d;
    end
  end

  assign o_money   = money_q;
  assign o_pending = pend_q;
endmodule

// File: tb/tb_coin_key_encoder.sv
// Directed bench for coin_key_encoder with CNT_MAX = 9 and a 20 ns clock.
module tb_coin_key_encoder;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       i_key_half = 1'b1;
  logic       i_key_one = 1'b1;
  logic [1:0] o_money;
  logic       o_pending;

  int n_chk = 0;
  int n_err = 0;

  coin_key_encoder #(.CNT_MAX(9)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_key_half(i_key_half),
    .i_key_one (i_key_one),
    .o_money   (o_money),
    .o_pending (o_pending)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Step one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int m, input int p);
    chk({tag, ".money"}, int'(o_money), m);
    chk({tag, ".pend"}, int'(o_pending), p);
  endtask

  task automatic idle(input string tag, input int n);
    i_key_half = 1'b1;
    i_key_one  = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk_out(tag, 0, 0);
    end
  endtask

  initial begin
    // Reset state
    sys_rst_n = 1'b0;
    tick(); tick();
    chk_out("reset", 0, 0);
    sys_rst_n = 1'b1;
    idle("post_reset", 3);

    // Clean half press: pulse after edge 11, silent while held
    i_key_half = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk_out($sformatf("clean_half@%0d", i), (i == 11) ? 1 : 0, 0);
    end
    idle("clean_rel", 4);

    // Bounce on the one-unit key; last fall at step 18, pulse 11 edges later
    for (int p = 0; p < 35; p++) begin
      i_key_one = (p < 20 && ((p / 3) % 2 == 1)) ? 1'b1 : 1'b0;
      tick();
      chk_out($sformatf("bounce@%0d", p), (p == 28) ? 2 : 0, 0);
    end
    idle("bounce_rel", 4);

    // Simultaneous: 2 then queued 1, pending only during the 2
    i_key_half = 1'b0;
    i_key_one  = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk_out($sformatf("simul@%0d", i), (i == 11) ? 2 : (i == 12) ? 1 : 0,
              (i == 11) ? 1 : 0);
    end
    idle("simul_rel", 4);

    // Reset mid-count (count 5 after edge 7), key held through reset
    i_key_one = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk_out($sformatf("rstcnt_pre@%0d", i), 0, 0);
    end
    sys_rst_n = 1'b0;
    tick();
    chk_out("rstcnt_in_reset", 0, 0);
    sys_rst_n = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk_out($sformatf("rstcnt_post@%0d", i), (i == 11) ? 2 : 0, 0);
    end
    idle("rstcnt_rel", 4);

    // Reset while the half coin is queued: it must be dropped
    i_key_half = 1'b0;
    i_key_one  = 1'b0;
    for (int i = 1; i <= 11; i++) tick();
    chk_out("rstpend_before", 2, 1);
    i_key_half = 1'b1;
    i_key_one  = 1'b1;
    sys_rst_n  = 1'b0;
    tick();
    chk_out("rstpend_in_reset", 0, 0);
    sys_rst_n = 1'b1;
    idle("rstpend_after", 15);

    // Fast re-press: release for one cycle, second pulse needs a full window
    for (int i = 1; i <= 28; i++) begin
      i_key_half = (i == 13) ? 1'b1 : 1'b0;
      tick();
      chk_out($sformatf("repress@%0d", i), (i == 11 || i == 24) ? 1 : 0, 0);
    end
    idle("repress_rel", 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
